// File: rtl/iack_ctrl.sv
// ---------------------------------------------------------------------------
// iack_ctrl
//   Interrupt-acknowledge controller for a 68000 bus, downstream of the IPL
//   encoder. When the CPU runs an IACK cycle, the requested level (A3..A1) is
//   compared with the active IPL code. The cycle is answered in one of three
//   ways: autovector (vpa_n), DUART vectored acknowledge (duart_iack_n with a
//   DTACK handshake and a timeout), or spurious (berr_n). A one-cycle
//   acknowledge strobe, the level of the last acknowledge and a saturating
//   spurious counter are provided for diagnostics.
//
//   Optional feature macro: DUART_VECTORED_EN
//     defined   : level DUART_LEVEL is acknowledged through duart_iack_n and
//                 waits for duart_dtack_n, with a TIMEOUT_CYCLES timeout
//     undefined : every valid level is autovectored, duart_iack_n is tied
//                 high and duart_dtack_n is ignored
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous active-low reset
//   as_n           in   CPU address strobe (asynchronous to clk)
//   fc[2:0]        in   CPU function code (asynchronous to clk)
//   addr[2:0]      in   CPU A3..A1, level being acknowledged (asynchronous)
//   ipl[2:0]       in   active encoded level, 0 = none (clk domain)
//   duart_dtack_n  in   DUART DTACK during vectored IACK (asynchronous)
//   vpa_n          out  autovector request
//   duart_iack_n   out  DUART IACK strobe
//   berr_n         out  bus error for spurious / timed-out IACK
//   iack_strobe    out  one-cycle pulse when an acknowledge is issued
//   iack_level     out  level of the last issued acknowledge
//   spurious_cnt   out  saturating count of BERR-terminated IACKs
// ---------------------------------------------------------------------------
module iack_ctrl #(
  parameter int unsigned DUART_LEVEL    = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             as_n,
  input  logic [2:0]       fc,
  input  logic [2:0]       addr,
  input  logic [2:0]       ipl,
  input  logic             duart_dtack_n,
  output logic             vpa_n,
  output logic             duart_iack_n,
  output logic             berr_n,
  output logic             iack_strobe,
  output logic [2:0]       iack_level,
  output logic [CNT_W-1:0] spurious_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_AUTOVEC  = 3'd2,
    ST_VECTORED = 3'd3,
    ST_TIMEOUT  = 3'd4,
    ST_SPURIOUS = 3'd5,
    ST_HOLD     = 3'd6
  } state_e;

  // Saturating increment: the diagnostic counter must never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       lvl_q, lvl_d;
  logic             vpa_n_q, vpa_n_d;
  logic             berr_n_q, berr_n_d;
  logic             strobe_q, strobe_d;
  logic [2:0]       level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser bundle {as_n, fc, addr}; reset value reads as bus idle.
  localparam logic [6:0] SYNC_RST = 7'b1_000_000;
  logic [6:0] meta_q, sync_q;
  logic       as_s, iack_s;
  logic [2:0] fc_s, addr_s;

  assign as_s   = sync_q[6];
  assign fc_s   = sync_q[5:3];
  assign addr_s = sync_q[2:0];
  assign iack_s = (as_s == 1'b0) && (fc_s == 3'b111);

  // Two-flop synchroniser for the asynchronous CPU bus signals.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= SYNC_RST;
      sync_q <= SYNC_RST;
    end else begin
      meta_q <= {as_n, fc, addr};
      sync_q <= meta_q;
    end
  end

`ifdef DUART_VECTORED_EN
  localparam logic [2:0] DUART_LVL = 3'(DUART_LEVEL);
  localparam logic [9:0] TMO_LAST  = 10'(TIMEOUT_CYCLES - 1);

  logic       dtack_meta_q, dtack_sync_q;
  logic [9:0] tmo_q, tmo_d;
  logic       diack_n_q, diack_n_d;

  // DTACK synchroniser and vectored-acknowledge timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dtack_meta_q <= 1'b1;
      dtack_sync_q <= 1'b1;
      tmo_q        <= 10'd0;
      diack_n_q    <= 1'b1;
    end else begin
      dtack_meta_q <= duart_dtack_n;
      dtack_sync_q <= dtack_meta_q;
      tmo_q        <= tmo_d;
      diack_n_q    <= diack_n_d;
    end
  end

  assign duart_iack_n = diack_n_q;
`else
  // Vectored path not built: keep the configuration inputs visibly consumed.
  logic        unused_dtack_s;
  logic [12:0] unused_cfg_s;
  assign unused_dtack_s = duart_dtack_n;
  assign unused_cfg_s   = {3'(DUART_LEVEL), 10'(TIMEOUT_CYCLES)};
  assign duart_iack_n   = 1'b1;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      lvl_q    <= 3'd0;
      vpa_n_q  <= 1'b1;
      berr_n_q <= 1'b1;
      strobe_q <= 1'b0;
      level_q  <= 3'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      vpa_n_q  <= vpa_n_d;
      berr_n_q <= berr_n_d;
      strobe_q <= strobe_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic; a synchronised as_n release always returns to IDLE.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
`ifdef DUART_VECTORED_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (iack_s) begin
          state_d = ST_DECODE;
          lvl_d   = addr_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (as_s) begin
          state_d = ST_IDLE;
        end else if ((lvl_q == 3'd0) || (lvl_q != ipl)) begin
          state_d = ST_SPURIOUS;
`ifdef DUART_VECTORED_EN
        end else if (lvl_q == DUART_LVL) begin
          state_d = ST_VECTORED;
          tmo_d   = 10'd0;
`endif
        end else begin
          state_d = ST_AUTOVEC;
        end
      end
`ifdef DUART_VECTORED_EN
      ST_VECTORED: begin
        if (as_s) begin
          state_d = ST_IDLE;
        end else if (dtack_sync_q == 1'b0) begin
          state_d = ST_HOLD;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end
      ST_TIMEOUT: begin
        if (as_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
`endif
      ST_AUTOVEC, ST_SPURIOUS, ST_HOLD: begin
        if (as_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: outputs are registered from the state being entered, so a
  // response appears on the same edge as the transition that causes it.
  always_comb begin
    vpa_n_d   = vpa_n_q;
    berr_n_d  = berr_n_q;
    strobe_d  = 1'b0;
    level_d   = level_q;
    cnt_d     = cnt_q;
`ifdef DUART_VECTORED_EN
    diack_n_d = diack_n_q;
`endif
    case (state_d)
      ST_IDLE: begin
        vpa_n_d   = 1'b1;
        berr_n_d  = 1'b1;
`ifdef DUART_VECTORED_EN
        diack_n_d = 1'b1;
`endif
      end
      ST_AUTOVEC: begin
        vpa_n_d  = 1'b0;
        strobe_d = 1'b1;
        level_d  = lvl_q;
      end
`ifdef DUART_VECTORED_EN
      ST_VECTORED: begin
        diack_n_d = 1'b0;
        if (state_q == ST_DECODE) begin
          strobe_d = 1'b1;
          level_d  = lvl_q;
        end else begin
          strobe_d = 1'b0;
        end
      end
      ST_TIMEOUT: begin
        diack_n_d = 1'b1;
        berr_n_d  = 1'b0;
        cnt_d     = sat_inc(cnt_q);
      end
`endif
      ST_SPURIOUS: begin
        berr_n_d = 1'b0;
        cnt_d    = sat_inc(cnt_q);
      end
      default: begin
        strobe_d = 1'b0;
      end
    endcase
  end

  assign vpa_n        = vpa_n_q;
  assign berr_n       = berr_n_q;
  assign iack_strobe  = strobe_q;
  assign iack_level   = level_q;
  assign spurious_cnt = cnt_q;

endmodule

// File: tb/tb_iack_ctrl.sv
module tb_iack_ctrl;
  localparam int T       = 64;
  localparam int CNT_MAX = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rst_next = 1'b0;
  logic       as_n = 1'b1;
  logic [2:0] fc = 3'd0;
  logic [2:0] addr = 3'd0;
  logic [2:0] ipl = 3'd0;
  logic       duart_dtack_n = 1'b1;
  logic       vpa_n, duart_iack_n, berr_n, iack_strobe;
  logic [2:0] iack_level;
  logic [7:0] spurious_cnt;

  iack_ctrl #(.DUART_LEVEL(5), .TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .as_n(as_n), .fc(fc), .addr(addr), .ipl(ipl),
    .duart_dtack_n(duart_dtack_n), .vpa_n(vpa_n), .duart_iack_n(duart_iack_n),
    .berr_n(berr_n), .iack_strobe(iack_strobe), .iack_level(iack_level),
    .spurious_cnt(spurious_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: expected outputs after the next clock edge.
  logic       e_vpa, e_diack, e_berr, e_strobe;
  logic [2:0] e_level;
  int         e_cnt;
  bit         in_txn, decided, waiting;
  int         vcount;
  logic [2:0] m_lvl;
  // Raw bus values sampled at the last two edges; [1] is what the design sees.
  logic       h_as [2];
  logic [2:0] h_fc [2];
  logic [2:0] h_addr [2];
  logic       h_dt [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_vpa = 1'b1; e_diack = 1'b1; e_berr = 1'b1; e_strobe = 1'b0;
    e_level = 3'd0; e_cnt = 0;
    in_txn = 1'b0; decided = 1'b0; waiting = 1'b0; vcount = 0; m_lvl = 3'd0;
    for (int i = 0; i < 2; i++) begin
      h_as[i] = 1'b1; h_fc[i] = 3'd0; h_addr[i] = 3'd0; h_dt[i] = 1'b1;
    end
  endtask

  task automatic bump();
    if (e_cnt < CNT_MAX) e_cnt++;
  endtask

  // Advance the model across one clock edge using the inputs just driven.
  task automatic model_step();
    logic as_s, dt_s;
    logic [2:0] fc_s, ad_s;
    if (!reset) begin
      model_reset();
      return;
    end
    as_s = h_as[1]; fc_s = h_fc[1]; ad_s = h_addr[1]; dt_s = h_dt[1];
    e_strobe = 1'b0;
    if (!in_txn) begin
      if (!as_s && fc_s == 3'd7) begin
        in_txn = 1'b1; decided = 1'b0; m_lvl = ad_s;
      end
    end else if (as_s) begin
      in_txn = 1'b0; waiting = 1'b0;
      e_vpa = 1'b1; e_diack = 1'b1; e_berr = 1'b1;
    end else if (!decided) begin
      decided = 1'b1;
      if (m_lvl == 3'd0 || m_lvl != ipl) begin
        e_berr = 1'b0;
        bump();
`ifdef DUART_VECTORED_EN
      end else if (m_lvl == 3'd5) begin
        e_diack = 1'b0; e_strobe = 1'b1; e_level = m_lvl;
        waiting = 1'b1; vcount = 0;
`endif
      end else begin
        e_vpa = 1'b0; e_strobe = 1'b1; e_level = m_lvl;
      end
    end else if (waiting) begin
      if (!dt_s) begin
        waiting = 1'b0;
      end else begin
        vcount++;
        if (vcount == T) begin
          waiting = 1'b0; e_diack = 1'b1; e_berr = 1'b0;
          bump();
        end
      end
    end
    h_as[1] = h_as[0];     h_as[0] = as_n;
    h_fc[1] = h_fc[0];     h_fc[0] = fc;
    h_addr[1] = h_addr[0]; h_addr[0] = addr;
    h_dt[1] = h_dt[0];     h_dt[0] = duart_dtack_n;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("vpa_n", vpa_n, e_vpa);
      check("duart_iack_n", duart_iack_n, e_diack);
      check("berr_n", berr_n, e_berr);
      check("iack_strobe", iack_strobe, e_strobe);
      check("iack_level", iack_level, e_level);
      check("spurious_cnt", spurious_cnt, e_cnt);
      check("one_low", ((!vpa_n) + (!duart_iack_n) + (!berr_n)) <= 1, 1);
    end
  end

  task automatic cyc(input logic a, input logic [2:0] f, input logic [2:0] ad,
                     input logic [2:0] ip, input logic dt);
    @(negedge clk);
    #1;
    reset = rst_next;
    as_n = a; fc = f; addr = ad; ipl = ip; duart_dtack_n = dt;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 3'd0, 3'd0, ipl, 1'b1);
  endtask

  task automatic iack(input logic [2:0] f, input logic [2:0] ad, input logic [2:0] ip,
                      input logic [2:0] ip2, input int low, input int dtd);
    for (int i = 0; i < low; i++)
      cyc(1'b0, f, ad, (i < 5) ? ip : ip2, (dtd >= 0 && i >= dtd) ? 1'b0 : 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 3'd0, 3'd0, ip2, 1'b1);
  endtask

  initial begin
    int base, i_d, i_b;
    bit berr_seen;
    logic [2:0] ad, ip, ip2, f;
    int low, dtd;

    // Reset values appear without any clock edge.
    #1 reset = 1'b0;
    model_reset();
    #1;
    check("rst_vpa", vpa_n, 1); check("rst_diack", duart_iack_n, 1);
    check("rst_berr", berr_n, 1); check("rst_strobe", iack_strobe, 0);
    check("rst_level", iack_level, 0); check("rst_cnt", spurious_cnt, 0);
    chk_en = 1'b1;
    idle(3);
    rst_next = 1'b1;
    idle(3);

    // Level 5 acknowledge: response on the 4th edge after as_n falls.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 3'd7, 3'd5, 3'd5, 1'b1);
      if (i == 3) begin
        check("d1_pre_vpa", vpa_n, 1); check("d1_pre_strobe", iack_strobe, 0);
      end
      if (i == 4) begin
`ifdef DUART_VECTORED_EN
        check("d1_diack", duart_iack_n, 0);
`else
        check("d1_vpa", vpa_n, 0);
`endif
        check("d1_strobe", iack_strobe, 1); check("d1_level", iack_level, 5);
      end
      if (i == 5) check("d1_strobe_end", iack_strobe, 0);
    end
    // Release: two synchroniser edges, then HOLD exits on the third edge.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 3'd0, 3'd0, 3'd5, 1'b1);
`ifdef DUART_VECTORED_EN
      if (i == 3) check("d1_release", duart_iack_n, 1);
`else
      if (i == 3) check("d1_release", vpa_n, 1);
`endif
    end

`ifdef DUART_VECTORED_EN
    // DTACK ten cycles after duart_iack_n falls: no bus error.
    berr_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 3'd7, 3'd5, 3'd5, (i >= 13) ? 1'b0 : 1'b1);
      if (berr_n == 1'b0) berr_seen = 1'b1;
      if (i == 29) check("d2_diack_held", duart_iack_n, 0);
    end
    idle(5);
    check("d2_no_berr", berr_seen, 0);
    check("d2_cnt", spurious_cnt, 0);

    // No DTACK: BERR exactly T cycles after duart_iack_n falls.
    i_d = -1; i_b = -1;
    for (int i = 0; i < 80; i++) begin
      cyc(1'b0, 3'd7, 3'd5, 3'd5, 1'b1);
      if (i_d < 0 && duart_iack_n == 1'b0) i_d = i;
      if (i_b < 0 && berr_n == 1'b0) begin
        i_b = i;
        check("d3_diack_off", duart_iack_n, 1);
      end
    end
    idle(5);
    check("d3_latency", i_b - i_d, T);
    check("d3_cnt", spurious_cnt, 1);
    base = 1;
`else
    base = 0;
`endif

    // Spurious: no pending interrupt.
    iack(3'd7, 3'd3, 3'd0, 3'd0, 6, -1);
    check("d4_cnt_inc", spurious_cnt, base + 1);
    for (int n = 0; n < 300; n++) iack(3'd7, 3'd3, 3'd0, 3'd0, 6, -1);
    check("d4_cnt_sat", spurious_cnt, 255);

    // Non-IACK bus cycle is ignored.
    for (int i = 0; i < 20; i++) cyc(1'b0, 3'd5, 3'd5, 3'd5, 1'b1);
    check("d6_vpa", vpa_n, 1); check("d6_berr", berr_n, 1);
    check("d6_diack", duart_iack_n, 1); check("d6_level", iack_level, 5);
    check("d6_cnt", spurious_cnt, 255);
    idle(3);

    // Asynchronous reset while holding vpa_n low.
    for (int i = 0; i < 8; i++) cyc(1'b0, 3'd7, 3'd2, 3'd2, 1'b1);
    check("d5_vpa_hold", vpa_n, 0);
    #2 reset = 1'b0;
    rst_next = 1'b0;
    model_reset();
    #1;
    check("d5_vpa_async", vpa_n, 1); check("d5_cnt_async", spurious_cnt, 0);
    check("d5_level_async", iack_level, 0);
    idle(2);
    rst_next = 1'b1;
    idle(2);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 3'd7, 3'd5, 3'd5, 1'b1);
      if (i == 4) begin
        check("d5_fresh_strobe", iack_strobe, 1); check("d5_fresh_level", iack_level, 5);
      end
    end
    idle(5);

    // Randomised traffic: aborts, mismatches, late DTACK, timeouts, ipl churn.
    for (int n = 0; n < 150; n++) begin
      f   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd7;
      ad  = 3'($urandom_range(0, 7));
      ip  = ($urandom_range(0, 1) == 1) ? ad : 3'($urandom_range(0, 7));
      ip2 = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : ip;
      low = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 75) : $urandom_range(1, 14);
      dtd = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(2, 30);
      iack(f, ad, ip, ip2, low, dtd);
      idle($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
